stpm_array: RTL and testbench

- Parametrised N-channel stepper motor controller; successor to the fixed 4-channel stepper bank.
- Each channel has its own command: direction, step count, start and abort.
- Each channel runs its own phase sequencer, in full-step or half-step mode, timed by a shared step-period prescaler value.
- Sits between the motion-command logic and the coil driver pins; per-channel busy/done handshake back to the commander.

---
 rtl/stpm_array.sv | 173 +++++++++++++++++
 tb/tb_stpm_array.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stpm_array.sv
// stpm_array: N-channel stepper motor phase sequencer.
//
// Each channel accepts a move command (direction, half/full-step mode,
// step count), latches it together with the shared step period, and walks
// its 8-entry coil phase table once per period until the count is exhausted.
// A one-cycle done pulse marks completion. The phase index survives between
// moves, so consecutive moves continue from the last coil position.
//
// Optional feature: define STPM_POS_EN to add o_Pos, a signed 16-bit
// per-channel position counter (+/-1 per half-step, +/-2 per full-step).
//
// Parameters:
//   NUM_CH  number of channels (1..16)
//   CYC_W   width of the per-channel step count
//   DIV_W   width of the clocks-per-step value
//
// Ports:
//   i_Clk      system clock
//   i_Rst      asynchronous active-low reset
//   i_Start    per-channel start strobe
//   i_Abort    per-channel abort strobe (wins over start)
//   i_Dir      per-channel direction, 1 = index increments
//   i_Half     per-channel mode, 1 = half-step
//   i_Cycles   per-channel step count, channel k at [k*CYC_W +: CYC_W]
//   i_Period   clocks per step, shared; 0 behaves as 1
//   o_Pwm      coil pattern, channel k at [k*4 +: 4]
//   o_Pos      (STPM_POS_EN only) position, channel k at [k*16 +: 16]
//   o_Busy     channel executing a move
//   o_Done     one-cycle completion pulse
//
// Per-channel states:
//   state   | meaning
//   ST_IDLE | coils off, waiting for a start
//   ST_RUN  | stepping; coils driven from the phase table
//   ST_DONE | one-cycle completion pulse, coils hold final position
module stpm_array #(
   parameter int NUM_CH = 4,
   parameter int CYC_W  = 10,
   parameter int DIV_W  = 16
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst,
   input  logic [NUM_CH-1:0]         i_Start,
   input  logic [NUM_CH-1:0]         i_Abort,
   input  logic [NUM_CH-1:0]         i_Dir,
   input  logic [NUM_CH-1:0]         i_Half,
   input  logic [NUM_CH*CYC_W-1:0]   i_Cycles,
   input  logic [DIV_W-1:0]          i_Period,
   output logic [NUM_CH*4-1:0]       o_Pwm,
`ifdef STPM_POS_EN
   output logic [NUM_CH*16-1:0]      o_Pos,
`endif
   output logic [NUM_CH-1:0]         o_Busy,
   output logic [NUM_CH-1:0]         o_Done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [3:0] phase_of(input logic [2:0] idx);
      logic [3:0] pat;
      pat = 4'b0000;
      case (idx)
         3'd0: pat = 4'b1000;
         3'd1: pat = 4'b1100;
         3'd2: pat = 4'b0100;
         3'd3: pat = 4'b0110;
         3'd4: pat = 4'b0010;
         3'd5: pat = 4'b0011;
         3'd6: pat = 4'b0001;
         3'd7: pat = 4'b1001;
         default: pat = 4'b0000;
      endcase
      return pat;
   endfunction

   // Period 0 is clamped to 1 so a zero period still advances every clock.
   logic [DIV_W-1:0] period_eff;
   assign period_eff = (i_Period == '0) ? DIV_W'(1) : i_Period;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      state_t           state_q, state_d;
      logic [2:0]       idx_q;
      logic             dir_q, half_q;
      logic [CYC_W-1:0] rem_q;
      logic [DIV_W-1:0] per_q, tmr_q;
      logic [CYC_W-1:0] cyc_in;
      logic             go, tc, last;
      logic [2:0]       step;

      assign cyc_in = i_Cycles[k*CYC_W +: CYC_W];
      assign go     = i_Start[k] & ~i_Abort[k];
      assign tc     = (tmr_q == '0);
      assign last   = (rem_q == CYC_W'(1));
      assign step   = half_q ? 3'd1 : 3'd2;

      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE: if (go) state_d = (cyc_in == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (i_Abort[k])       state_d = ST_IDLE;
               else if (tc && last)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge i_Clk or negedge i_Rst) begin
         if (!i_Rst) state_q <= ST_IDLE;
         else        state_q <= state_d;
      end

      // The step timer counts down from period-1; reaching zero is one step.
      always_ff @(posedge i_Clk or negedge i_Rst) begin
         if (!i_Rst) begin
            idx_q  <= '0;
            dir_q  <= 1'b0;
            half_q <= 1'b0;
            rem_q  <= '0;
            per_q  <= '0;
            tmr_q  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (go) begin
                     dir_q  <= i_Dir[k];
                     half_q <= i_Half[k];
                     rem_q  <= cyc_in;
                     per_q  <= period_eff;
                     tmr_q  <= period_eff - DIV_W'(1);
                     // Full-step walks even entries only.
                     if (!i_Half[k]) idx_q[0] <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (!i_Abort[k]) begin
                     if (tc) begin
                        idx_q <= dir_q ? idx_q + step : idx_q - step;
                        rem_q <= rem_q - CYC_W'(1);
                        tmr_q <= per_q - DIV_W'(1);
                     end else begin
                        tmr_q <= tmr_q - DIV_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end

`ifdef STPM_POS_EN
      logic [15:0] pos_q;
      always_ff @(posedge i_Clk or negedge i_Rst) begin
         if (!i_Rst) begin
            pos_q <= '0;
         end else if (state_q == ST_RUN && !i_Abort[k] && tc) begin
            pos_q <= dir_q ? pos_q + {13'd0, step} : pos_q - {13'd0, step};
         end
      end
      assign o_Pos[k*16 +: 16] = pos_q;
`endif

      assign o_Pwm[k*4 +: 4] = (state_q == ST_IDLE) ? 4'b0000 : phase_of(idx_q);
      assign o_Busy[k]       = (state_q == ST_RUN);
      assign o_Done[k]       = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_stpm_array.sv
`timescale 1ns/1ps
module tb_stpm_array;
   localparam int NUM_CH = 4;
   localparam int CYC_W  = 10;
   localparam int DIV_W  = 16;
   localparam logic [3:0] PHASE [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};

   logic                    i_Clk = 1'b0;
   logic                    i_Rst = 1'b0;
   logic [NUM_CH-1:0]       i_Start, i_Abort, i_Dir, i_Half;
   logic [NUM_CH*CYC_W-1:0] i_Cycles;
   logic [DIV_W-1:0]        i_Period;
   logic [NUM_CH*4-1:0]     o_Pwm;
   logic [NUM_CH-1:0]       o_Busy, o_Done;
`ifdef STPM_POS_EN
   logic [NUM_CH*16-1:0]    o_Pos;
`endif

   stpm_array #(.NUM_CH(NUM_CH), .CYC_W(CYC_W), .DIV_W(DIV_W)) u_dut (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Start  (i_Start),
      .i_Abort  (i_Abort),
      .i_Dir    (i_Dir),
      .i_Half   (i_Half),
      .i_Cycles (i_Cycles),
      .i_Period (i_Period),
      .o_Pwm    (o_Pwm),
`ifdef STPM_POS_EN
      .o_Pos    (o_Pos),
`endif
      .o_Busy   (o_Busy),
      .o_Done   (o_Done)
   );

   always #5 i_Clk = ~i_Clk;

   // Cycle n is the interval following rising edge n.
   int cyc = 0;
   always @(posedge i_Clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          cyc;
      bit          busy;
      bit          done;
      logic [3:0]  pwm;
      logic [15:0] pos;
   } exp_t;

   exp_t sbq [NUM_CH][$];

   // Reference model: one record per channel describing the current move.
   int m_idx [NUM_CH];
   int m_pos [NUM_CH];
   int m_n   [NUM_CH];
   int m_len [NUM_CH];
   int m_last[NUM_CH];
   int m_p   [NUM_CH];
   int m_i0  [NUM_CH];
   int m_p0  [NUM_CH];
   int m_sd  [NUM_CH];
   bit m_act [NUM_CH];

   logic [NUM_CH-1:0] s_start, s_abort, s_dir, s_half;
   int s_cyc [NUM_CH];
   int s_per;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endfunction

   function automatic void model_ch(int k, int c);
      bit   idle, run;
      int   p, cc, sd, i0, steps;
      exp_t e;
      idle = !m_act[k] || c > m_last[k];
      run  = m_act[k] && c >= m_n[k] && c < m_n[k] + m_len[k] && c <= m_last[k];
      if (idle && s_start[k] && !s_abort[k]) begin
         p  = (s_per == 0) ? 1 : s_per;
         cc = s_cyc[k];
         sd = (s_half[k] ? 1 : 2) * (s_dir[k] ? 1 : -1);
         i0 = s_half[k] ? m_idx[k] : (m_idx[k] & 6);
         m_act[k] = 1'b1;
         m_n[k]   = c + 1;
         m_len[k] = cc * p;
         m_last[k] = c + 1 + cc * p;
         m_p[k]  = p;
         m_sd[k] = sd;
         m_i0[k] = i0;
         m_p0[k] = m_pos[k];
         for (int j = 0; j < cc * p; j++) begin
            e.cyc  = c + 1 + j;
            e.busy = 1'b1;
            e.done = 1'b0;
            e.pwm  = PHASE[(i0 + sd * (j / p)) & 7];
            e.pos  = 16'(m_pos[k] + sd * (j / p));
            sbq[k].push_back(e);
         end
         e.cyc  = c + 1 + cc * p;
         e.busy = 1'b0;
         e.done = 1'b1;
         e.pwm  = PHASE[(i0 + sd * cc) & 7];
         e.pos  = 16'(m_pos[k] + sd * cc);
         sbq[k].push_back(e);
         m_idx[k] = (i0 + sd * cc) & 7;
         m_pos[k] = m_pos[k] + sd * cc;
      end else if (run && s_abort[k]) begin
         steps = (c - m_n[k]) / m_p[k];
         m_idx[k]  = (m_i0[k] + m_sd[k] * steps) & 7;
         m_pos[k]  = m_p0[k] + m_sd[k] * steps;
         m_last[k] = c;
         while (sbq[k].size() > 0 && sbq[k][$].cyc > c) void'(sbq[k].pop_back());
      end
   endfunction

   // Apply this cycle's stimulus, then advance to the next cycle and
   // re-randomise the non-strobe inputs (they must not disturb a running move).
   task automatic step_cycle();
      for (int k = 0; k < NUM_CH; k++) model_ch(k, cyc);
      i_Start  = s_start;
      i_Abort  = s_abort;
      i_Dir    = s_dir;
      i_Half   = s_half;
      i_Period = DIV_W'(s_per);
      for (int k = 0; k < NUM_CH; k++) i_Cycles[k*CYC_W +: CYC_W] = CYC_W'(s_cyc[k]);
      @(posedge i_Clk);
      #1;
      s_start = '0;
      s_abort = '0;
      s_dir   = NUM_CH'($urandom);
      s_half  = NUM_CH'($urandom);
      for (int k = 0; k < NUM_CH; k++) s_cyc[k] = $urandom_range(0, 7);
      s_per = $urandom_range(0, 4);
   endtask

   task automatic cmd(int k, bit dir, bit half, int cc);
      s_start[k] = 1'b1;
      s_dir[k]   = dir;
      s_half[k]  = half;
      s_cyc[k]   = cc;
   endtask

   function automatic bit pending();
      bit r;
      r = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
         if ((m_act[k] && cyc <= m_last[k]) || sbq[k].size() > 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(int budget);
      int n;
      n = 0;
      while (pending()) begin
         if (n == budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain timeout at cyc %0d", cyc);
            return;
         end
         step_cycle();
         n++;
      end
      step_cycle();
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         sbq[k].delete();
         m_act[k] = 1'b0;
         m_idx[k] = 0;
         m_pos[k] = 0;
         m_last[k] = 0;
      end
   endtask

   // Monitor: pops the scoreboard whenever a channel shows busy or done.
   always @(negedge i_Clk) begin
      if (i_Rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            exp_t        e;
            logic [15:0] pos;
`ifdef STPM_POS_EN
            pos = o_Pos[k*16 +: 16];
`else
            pos = 16'd0;
`endif
            if (o_Busy[k] || o_Done[k]) begin
               n_checks++;
               if (sbq[k].size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected output ch%0d cyc %0d: busy=%0b done=%0b pwm=%b",
                           k, cyc, o_Busy[k], o_Done[k], o_Pwm[k*4 +: 4]);
               end else begin
                  e = sbq[k].pop_front();
                  if (e.cyc != cyc || e.busy != o_Busy[k] || e.done != o_Done[k] ||
                      e.pwm !== o_Pwm[k*4 +: 4]
`ifdef STPM_POS_EN
                      || e.pos !== pos
`endif
                     ) begin
                     n_errors++;
                     $display("FAIL output ch%0d cyc %0d: got busy=%0b done=%0b pwm=%b pos=%0d want cyc %0d busy=%0b done=%0b pwm=%b pos=%0d",
                              k, cyc, o_Busy[k], o_Done[k], o_Pwm[k*4 +: 4], $signed(pos),
                              e.cyc, e.busy, e.done, e.pwm, $signed(e.pos));
                  end
               end
            end else begin
               chk($sformatf("idle pwm ch%0d cyc %0d", k, cyc), 64'(o_Pwm[k*4 +: 4]), 64'd0);
               if (sbq[k].size() > 0 && sbq[k][0].cyc <= cyc) begin
                  e = sbq[k].pop_front();
                  n_checks++;
                  n_errors++;
                  $display("FAIL missing output ch%0d cyc %0d: got idle want busy=%0b done=%0b pwm=%b",
                           k, cyc, e.busy, e.done, e.pwm);
               end
            end
         end
      end
   end

   initial begin
      s_start = '0; s_abort = '0; s_dir = '0; s_half = '0; s_per = 1;
      for (int k = 0; k < NUM_CH; k++) s_cyc[k] = 0;
      i_Start = '0; i_Abort = '0; i_Dir = '0; i_Half = '0;
      i_Cycles = '0; i_Period = '0;
      model_reset();

      repeat (2) @(posedge i_Clk);
      #1;
      chk("reset pwm",  64'(o_Pwm),  64'd0);
      chk("reset busy", 64'(o_Busy), 64'd0);
      chk("reset done", 64'(o_Done), 64'd0);
`ifdef STPM_POS_EN
      chk("reset pos",  64'(o_Pos),  64'd0);
`endif
      i_Rst = 1'b1;
      step_cycle();

      // Half-step forward, 3 steps of 2 clocks.
      cmd(0, 1'b1, 1'b1, 3); s_per = 2;
      step_cycle();
      drain(100);

      // Full-step reverse from idx 0.
      cmd(1, 1'b0, 1'b0, 2); s_per = 1;
      step_cycle();
      drain(100);

      // Zero-length move.
      cmd(2, 1'b1, 1'b1, 0); s_per = 3;
      step_cycle();
      drain(100);

      // Long move aborted after 10 clocks, then resumed.
      cmd(0, 1'b1, 1'b1, 100); s_per = 4;
      step_cycle();
      repeat (9) step_cycle();
      s_abort[0] = 1'b1;
      step_cycle();
      drain(100);
      cmd(0, 1'b1, 1'b1, 3); s_per = 1;
      step_cycle();
      drain(100);

      // Abort together with start in idle: nothing happens.
      cmd(3, 1'b1, 1'b0, 4); s_abort[3] = 1'b1; s_per = 1;
      step_cycle();
      drain(100);

      // All channels at once, with a start on a running channel.
      for (int k = 0; k < NUM_CH; k++) cmd(k, 1'(k & 1), 1'(k >> 1), k + 1);
      s_per = 3;
      step_cycle();
      repeat (2) step_cycle();
      cmd(3, 1'b0, 1'b1, 7);
      step_cycle();
      drain(100);

      // Randomised commands and aborts.
      repeat (400) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if ($urandom_range(0, 5) == 0)  s_start[k] = 1'b1;
            if ($urandom_range(0, 19) == 0) s_abort[k] = 1'b1;
         end
         step_cycle();
      end
      drain(500);

      // Reset in the middle of a move, off the clock edge.
      cmd(0, 1'b1, 1'b1, 50); cmd(1, 1'b1, 1'b0, 20); s_per = 2;
      step_cycle();
      repeat (6) step_cycle();
      i_Start = '0;
      i_Abort = '0;
      #2 i_Rst = 1'b0;
      #1;
      chk("async reset pwm",  64'(o_Pwm),  64'd0);
      chk("async reset busy", 64'(o_Busy), 64'd0);
      chk("async reset done", 64'(o_Done), 64'd0);
`ifdef STPM_POS_EN
      chk("async reset pos",  64'(o_Pos),  64'd0);
`endif
      model_reset();
      @(posedge i_Clk);
      @(posedge i_Clk);
      #3 i_Rst = 1'b1;
      cmd(0, 1'b1, 1'b1, 2); cmd(1, 1'b0, 1'b1, 2); s_per = 1;
      step_cycle();
      drain(100);

      for (int k = 0; k < NUM_CH; k++)
         chk($sformatf("leftover expectations ch%0d", k), 64'(sbq[k].size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
